// File: rtl/sdram_sd_dumper.sv
// sdram_sd_dumper: copies NUM_BLOCKS consecutive 512-byte blocks from SDRAM
// (256 x 16-bit words each) into consecutive SD card blocks. Each block is
// burst-read into a 128x32 staging buffer and then handed to the SD
// controller as a single write command. The controller fetches the buffer
// through a registered random-access port.
module sdram_sd_dumper #(
  parameter int unsigned NUM_BLOCKS     = 'd1,
  parameter logic [31:0] SD_START_BLOCK = 'd0,
  parameter logic [23:0] SDRAM_BASE     = 'd0,
  parameter int unsigned TIMEOUT        = 'd65535
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        Dump_En,
  output logic        Dump_Complite,
  output logic        Dump_Fail,

  input  logic        SD_Init_Complite,
  output logic [31:0] SD_Addr_Block,
  output logic        SD_Enable,
  output logic        SD_we,
  input  logic        SD_Complite,
  input  logic        SD_Fail,
  input  logic [31:0] SD_InPut_Data_Addr,
  output logic [31:0] SD_InPut_Data,

  output logic [23:0] m_addr_read,
  output logic        m_valid_read,
  output logic        Serial_access_read,
  input  logic        m_ready_read,
  input  logic [15:0] m_out_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_INIT,
    S_READ,
    S_SD_WRITE,
    S_SD_RELEASE,
    S_NEXT,
    S_COMPLITE,
    S_FAIL
  } state_t;

  localparam logic [15:0] LastBlk = 16'(NUM_BLOCKS - 1);
  // The stall counter trips on the edge where it would reach TIMEOUT.
  localparam logic [31:0] TmoLast = 32'(TIMEOUT - 1);

  state_t      state;
  logic [15:0] blk;
  logic [7:0]  wc;
  logic [31:0] tmo;
  logic [23:0] rd_addr;
  logic [15:0] lo_half;
  logic [31:0] data_buf [128];

  // Only the low seven index bits address the 128-entry buffer.
  logic [24:0] unused_addr_bits;
  assign unused_addr_bits = SD_InPut_Data_Addr[31:7];

  // rd_addr is itself the registered SDRAM address output.
  assign m_addr_read = rd_addr;

  // Main sequencer: SDRAM burst read, SD write handshake, completion/failure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= S_IDLE;
      blk                <= '0;
      wc                 <= '0;
      tmo                <= '0;
      rd_addr            <= '0;
      lo_half            <= '0;
      m_valid_read       <= 1'b0;
      Serial_access_read <= 1'b0;
      SD_Addr_Block      <= '0;
      SD_Enable          <= 1'b0;
      SD_we              <= 1'b0;
      Dump_Complite      <= 1'b0;
      Dump_Fail          <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (Dump_En) begin
            blk     <= '0;
            rd_addr <= SDRAM_BASE;
            state   <= S_WAIT_INIT;
          end
        end

        S_WAIT_INIT: begin
          if (SD_Init_Complite) begin
            wc                 <= '0;
            tmo                <= '0;
            m_valid_read       <= 1'b1;
            Serial_access_read <= 1'b1;
            state              <= S_READ;
          end
        end

        S_READ: begin
          if (m_ready_read) begin
            tmo     <= '0;
            rd_addr <= rd_addr + 24'd1;
            wc      <= wc + 8'd1;
            // Even words are parked until their odd partner arrives.
            if (!wc[0]) begin
              lo_half <= m_out_data;
            end
            if (wc == 8'd255) begin
              m_valid_read       <= 1'b0;
              Serial_access_read <= 1'b0;
              SD_Addr_Block      <= SD_START_BLOCK + {16'd0, blk};
              SD_Enable          <= 1'b1;
              SD_we              <= 1'b1;
              state              <= S_SD_WRITE;
            end else begin
              // Continuation drops for the final word of the burst.
              Serial_access_read <= (wc != 8'd254);
            end
          end else if (tmo == TmoLast) begin
            m_valid_read       <= 1'b0;
            Serial_access_read <= 1'b0;
            Dump_Fail          <= 1'b1;
            state              <= S_FAIL;
          end else begin
            tmo <= tmo + 32'd1;
          end
        end

        S_SD_WRITE: begin
          // A failure report takes priority over a simultaneous completion.
          if (SD_Fail) begin
            SD_Enable <= 1'b0;
            SD_we     <= 1'b0;
            Dump_Fail <= 1'b1;
            state     <= S_FAIL;
          end else if (SD_Complite) begin
            SD_Enable <= 1'b0;
            SD_we     <= 1'b0;
            state     <= S_SD_RELEASE;
          end
        end

        S_SD_RELEASE: begin
          if (!SD_Complite && !SD_Fail) begin
            state <= S_NEXT;
          end
        end

        S_NEXT: begin
          if (blk == LastBlk) begin
            Dump_Complite <= 1'b1;
            state         <= S_COMPLITE;
          end else begin
            blk                <= blk + 16'd1;
            wc                 <= '0;
            tmo                <= '0;
            m_valid_read       <= 1'b1;
            Serial_access_read <= 1'b1;
            state              <= S_READ;
          end
        end

        S_COMPLITE: begin
          if (!Dump_En) begin
            Dump_Complite <= 1'b0;
            state         <= S_IDLE;
          end
        end

        S_FAIL: begin
          SD_Enable <= 1'b0;
          if (!Dump_En) begin
            Dump_Fail <= 1'b0;
            state     <= S_IDLE;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Staging buffer fill: a 32-bit entry is written once its high half lands.
  always_ff @(posedge clk) begin
    if (state == S_READ && m_ready_read && wc[0]) begin
      data_buf[wc[7:1]] <= {m_out_data, lo_half};
    end
  end

  // Registered buffer read port for the SD controller.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      SD_InPut_Data <= '0;
    end else begin
      SD_InPut_Data <= data_buf[SD_InPut_Data_Addr[6:0]];
    end
  end

endmodule

// File: tb/tb_sdram_sd_dumper.sv
// Scoreboard bench for sdram_sd_dumper: 3 blocks, SD start 100, SDRAM base 0x1000,
// stall timeout 16. Stimulus pushes expected SD commands, buffer words and run
// outcomes; a monitor pops and compares as the DUT presents them.
module tb_sdram_sd_dumper;

  localparam logic [23:0] Base  = 24'h1000;
  localparam logic [31:0] Start = 32'd100;

  logic        clk = 1'b0;
  logic        rst;
  logic        Dump_En;
  logic        Dump_Complite;
  logic        Dump_Fail;
  logic        SD_Init_Complite;
  logic [31:0] SD_Addr_Block;
  logic        SD_Enable;
  logic        SD_we;
  logic        SD_Complite;
  logic        SD_Fail;
  logic [31:0] SD_InPut_Data_Addr;
  logic [31:0] SD_InPut_Data;
  logic [23:0] m_addr_read;
  logic        m_valid_read;
  logic        Serial_access_read;
  logic        m_ready_read;
  logic [15:0] m_out_data;

  sdram_sd_dumper #(
    .NUM_BLOCKS    (3),
    .SD_START_BLOCK(Start),
    .SDRAM_BASE    (Base),
    .TIMEOUT       (16)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .Dump_En           (Dump_En),
    .Dump_Complite     (Dump_Complite),
    .Dump_Fail         (Dump_Fail),
    .SD_Init_Complite  (SD_Init_Complite),
    .SD_Addr_Block     (SD_Addr_Block),
    .SD_Enable         (SD_Enable),
    .SD_we             (SD_we),
    .SD_Complite       (SD_Complite),
    .SD_Fail           (SD_Fail),
    .SD_InPut_Data_Addr(SD_InPut_Data_Addr),
    .SD_InPut_Data     (SD_InPut_Data),
    .m_addr_read       (m_addr_read),
    .m_valid_read      (m_valid_read),
    .Serial_access_read(Serial_access_read),
    .m_ready_read      (m_ready_read),
    .m_out_data        (m_out_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  done;   // {Dump_Complite, Dump_Fail}
    logic [23:0] addr;
    int          words;
    int          stalls; // -1: not compared
  } end_t;

  end_t        end_q[$];
  logic [31:0] addr_q[$];
  logic [31:0] data_q[$];

  int          checks = 0;
  int          failures = 0;
  int          words = 0;
  int          stalls = 0;
  bit          sdram_stall = 1'b0;
  bit          rd_req = 1'b0;
  logic [31:0] fail_addr = 32'hFFFF_FFFF;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    failures++;
    $display("FAIL %s: event not expected or never arrived", name);
  endtask

  function automatic int sd_idx(input int i);
    return (i == 0) ? 0 : (i == 1) ? 1 : 127;
  endfunction

  // Block b, buffer entry k holds SDRAM words 2k (low) and 2k+1 (high).
  function automatic logic [31:0] exp_word(input int b, input int k);
    logic [15:0] lo;
    lo = 16'(32'(Base) + 32'(256 * b + 2 * k));
    return {lo + 16'd1, lo};
  endfunction

  task automatic push_run(input int ncmd, input logic [1:0] done, input logic [23:0] addr,
                          input int nwords, input int nstalls);
    end_t e;
    for (int b = 0; b < ncmd; b++) begin
      addr_q.push_back(Start + 32'(b));
      for (int i = 0; i < 3; i++) data_q.push_back(exp_word(b, sd_idx(i)));
    end
    e.done   = done;
    e.addr   = addr;
    e.words  = nwords;
    e.stalls = nstalls;
    end_q.push_back(e);
  endtask

  // SDRAM model: data = low address bits, one idle cycle in five unless stalled.
  initial begin
    int gap;
    gap = 0;
    m_ready_read = 1'b0;
    m_out_data   = '0;
    forever begin
      @(negedge clk);
      gap++;
      if (rst) begin
        words = 0;
        stalls = 0;
        m_ready_read = 1'b0;
      end else begin
        m_ready_read = m_valid_read && !sdram_stall && (gap % 5 != 4);
        m_out_data   = m_addr_read[15:0];
        if (m_ready_read) words++;
        else if (m_valid_read) stalls++;
      end
    end
  end

  // SD slave: reads three buffer entries, then completes or fails the command.
  initial begin
    SD_Complite = 1'b0;
    SD_Fail = 1'b0;
    SD_InPut_Data_Addr = '0;
    forever begin
      @(negedge clk);
      rd_req = 1'b0;
      if (SD_Enable && SD_we) begin
        for (int i = 0; i < 3; i++) begin
          SD_InPut_Data_Addr = 32'(sd_idx(i));
          rd_req = 1'b1;
          @(negedge clk);
        end
        rd_req = 1'b0;
        if (SD_Addr_Block == fail_addr) SD_Fail = 1'b1;
        else SD_Complite = 1'b1;
        for (int n = 0; n < 100 && SD_Enable; n++) @(negedge clk);
        SD_Complite = 1'b0;
        SD_Fail = 1'b0;
      end
    end
  end

  // Monitor: compares DUT-presented events against the scoreboard queues.
  initial begin
    int   words_base, stalls_base;
    logic prev_en, prev_done, done;
    end_t e;
    words_base = 0;
    stalls_base = 0;
    prev_en = 1'b0;
    prev_done = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (rst) begin
        words_base = 0;
        stalls_base = 0;
        prev_en = 1'b0;
        prev_done = 1'b0;
      end else begin
        if (m_valid_read)
          check("serial_access", 32'(Serial_access_read), 32'(m_addr_read[7:0] != 8'hFF));
        if (rd_req) begin
          if (data_q.size() == 0) unexpected("sd_data");
          else check("sd_data", SD_InPut_Data, data_q.pop_front());
        end
        if (SD_Enable && !prev_en) begin
          if (addr_q.size() == 0) unexpected("sd_cmd");
          else check("sd_addr_block", SD_Addr_Block, addr_q.pop_front());
          check("sd_we", 32'(SD_we), 32'd1);
        end
        prev_en = SD_Enable;
        done = Dump_Complite || Dump_Fail;
        if (done && !prev_done) begin
          if (end_q.size() == 0) unexpected("run_end");
          else begin
            e = end_q.pop_front();
            check("end_code", 32'({Dump_Complite, Dump_Fail}), 32'(e.done));
            check("end_m_addr", 32'(m_addr_read), 32'(e.addr));
            check("end_words", 32'(words - words_base), 32'(e.words));
            if (e.stalls >= 0) check("end_stalls", 32'(stalls - stalls_base), 32'(e.stalls));
            check("end_valid_low", 32'(m_valid_read), 32'd0);
            check("end_sd_en_low", 32'(SD_Enable), 32'd0);
          end
          words_base = words;
          stalls_base = stalls;
        end
        prev_done = done;
      end
    end
  end

  task automatic wait_done(input string name);
    for (int n = 0; n < 5000 && !(Dump_Complite || Dump_Fail); n++) @(negedge clk);
    if (!(Dump_Complite || Dump_Fail)) unexpected(name);
    @(negedge clk);
  endtask

  task automatic release_run(input string name);
    Dump_En = 1'b0;
    repeat (2) @(negedge clk);
    check(name, 32'({Dump_Complite, Dump_Fail}), 32'd0);
  endtask

  // Directed stimulus.
  initial begin
    int vcount, wsnap;
    rst = 1'b1;
    Dump_En = 1'b0;
    SD_Init_Complite = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_outputs", 32'({SD_Enable, SD_we, m_valid_read, Serial_access_read,
                              Dump_Complite, Dump_Fail}), 32'd0);
    check("rst_sd_addr", SD_Addr_Block, 32'd0);
    check("rst_m_addr", 32'(m_addr_read), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // SD controller not ready for 50 cycles: no SDRAM request may appear.
    SD_Init_Complite = 1'b0;
    push_run(3, 2'b10, 24'h1300, 768, -1);
    Dump_En = 1'b1;
    vcount = 0;
    repeat (50) begin
      @(negedge clk);
      if (m_valid_read) vcount++;
    end
    check("valid_before_init", 32'(vcount), 32'd0);
    SD_Init_Complite = 1'b1;
    wait_done("run1_timeout");
    repeat (5) @(negedge clk);
    check("complite_held", 32'(Dump_Complite), 32'd1);
    release_run("run1_release");

    // Second full copy after Dump_En re-raised.
    push_run(3, 2'b10, 24'h1300, 768, -1);
    Dump_En = 1'b1;
    wait_done("run2_timeout");
    release_run("run2_release");

    // SD failure on the second block.
    fail_addr = Start + 32'd1;
    push_run(2, 2'b01, 24'h1200, 512, -1);
    Dump_En = 1'b1;
    wait_done("run3_timeout");
    wsnap = words;
    repeat (50) @(negedge clk);
    check("no_third_read", 32'(words), 32'(wsnap));
    check("fail_held", 32'(Dump_Fail), 32'd1);
    check("fail_sd_en", 32'(SD_Enable), 32'd0);
    release_run("run3_release");
    fail_addr = 32'hFFFF_FFFF;

    // SDRAM never ready: timeout after 16 stalled cycles.
    sdram_stall = 1'b1;
    push_run(0, 2'b01, Base, 0, 16);
    Dump_En = 1'b1;
    wait_done("run4_timeout");
    check("stall_valid_low", 32'(m_valid_read), 32'd0);
    release_run("run4_release");
    sdram_stall = 1'b0;

    // Reset after word 100 of the first burst, then restart from SDRAM_BASE.
    push_run(3, 2'b10, 24'h1300, 768, -1);
    Dump_En = 1'b1;
    for (int n = 0; n < 2000 && m_addr_read != 24'h1065; n++) begin
      @(posedge clk);
      #3;
    end
    if (m_addr_read != 24'h1065) unexpected("reach_word_100");
    rst = 1'b1;
    #1;
    check("midrst_ctrl", 32'({SD_Enable, SD_we, m_valid_read, Serial_access_read,
                              Dump_Complite, Dump_Fail}), 32'd0);
    check("midrst_m_addr", 32'(m_addr_read), 32'd0);
    check("midrst_sd_addr", SD_Addr_Block, 32'd0);
    check("midrst_sd_data", SD_InPut_Data, 32'd0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    for (int n = 0; n < 100 && !m_valid_read; n++) @(negedge clk);
    check("restart_addr", 32'(m_addr_read), 32'(Base));
    wait_done("run5_timeout");
    release_run("run5_release");

    repeat (5) @(negedge clk);
    check("addr_q_empty", 32'(addr_q.size()), 32'd0);
    check("data_q_empty", 32'(data_q.size()), 32'd0);
    check("end_q_empty", 32'(end_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
